// File: rtl/console_input_pkg.sv
// Shared types and constants for the console-input path.
// Echo of accepted symbols is built only when CONSOLE_ECHO_EN is defined.
package console_input_pkg;

  // Default FIFO depth and the symbol value meaning "no key".
  localparam int         CONSOLE_FIFO_DEPTH  = 16;
  localparam logic [7:0] CONSOLE_NULL_SYMBOL = 8'h00;

  // Four-phase Cin/CinAcq handshake states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_ACK     = 2'd2,
    ST_RELEASE = 2'd3
  } cin_state_t;

endpackage

// File: rtl/console_input_sync_fifo.sv
// Small symbol FIFO: storage array, wrapping pointers, saturating count.
// A pop and a push on the same edge are both honoured, even when full.
// flush clears the FIFO and discards any push on the same edge.
module sync_fifo #(
  parameter  int DEPTH      = 16,
  parameter  int DATA_WIDTH = 8,
  localparam int AW         = $clog2(DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] head,
  output logic                  push_accept,
  output logic                  full,
  output logic                  empty,
  output logic [CW-1:0]         count
);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]         head_ptr_q, head_ptr_d;
  logic [AW-1:0]         tail_ptr_q, tail_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_pop;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem_q[head_ptr_q];

  // Decide which operations take effect and compute next pointers/count.
  always_comb begin
    do_pop      = pop && !empty && !flush;
    push_accept = push && !flush && (!full || do_pop);
    head_ptr_d  = head_ptr_q;
    tail_ptr_d  = tail_ptr_q;
    count_d     = count_q;
    if (flush) begin
      head_ptr_d = '0;
      tail_ptr_d = '0;
      count_d    = '0;
    end else begin
      if (do_pop)      head_ptr_d = head_ptr_q + AW'(1);
      if (push_accept) tail_ptr_d = tail_ptr_q + AW'(1);
      count_d = count_q + CW'(push_accept) - CW'(do_pop);
    end
  end

  // Pointer and occupancy registers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_ptr_q <= '0;
      tail_ptr_q <= '0;
      count_q    <= '0;
    end else begin
      head_ptr_q <= head_ptr_d;
      tail_ptr_q <= tail_ptr_d;
      count_q    <= count_d;
    end
  end

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(negedge clk) begin
    if (push_accept) mem_q[tail_ptr_q] <= wdata;
  end

endmodule

// File: rtl/console_input.sv
// Console input: key edge capture into a FIFO, Cin/CinAcq delivery to the CPU,
// sticky overflow, and optional echo strobe (macro CONSOLE_ECHO_EN).
module console_input
  import console_input_pkg::*;
#(
  parameter  int DEPTH      = CONSOLE_FIFO_DEPTH,
  parameter  int DATA_WIDTH = 8,
  localparam int CW         = $clog2(DEPTH) + 1
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic [DATA_WIDTH-1:0] key_symbol,
  input  logic                  key_pressed,
  input  logic                  flush,
  input  logic                  Cin,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  CinAcq,
  output logic [CW-1:0]         fifo_count,
  output logic                  empty,
  output logic                  overflow,
  output logic                  echo_stb,
  output logic [DATA_WIDTH-1:0] echo_symbol
);

  cin_state_t            state_q, state_d;
  logic                  key_prev_q, key_prev_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic                  cin_acq_q, cin_acq_d;
  logic                  overflow_q, overflow_d;
  logic                  push_req, pop_req, push_accept;
  logic                  fifo_full, fifo_empty;
  logic [DATA_WIDTH-1:0] fifo_head;

  sync_fifo #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fifo (
    .clk         (Clk),
    .rst_n       (Rst_n),
    .flush       (flush),
    .push        (push_req),
    .pop         (pop_req),
    .wdata       (key_symbol),
    .head        (fifo_head),
    .push_accept (push_accept),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .count       (fifo_count)
  );

  assign empty    = fifo_empty;
  assign data_out = data_out_q;
  assign CinAcq   = cin_acq_q;
  assign overflow = overflow_q;

  // Key edge detect, handshake next state and sticky overflow.
  always_comb begin
    key_prev_d = key_pressed;
    push_req   = key_pressed && !key_prev_q &&
                 (key_symbol != DATA_WIDTH'(CONSOLE_NULL_SYMBOL));
    pop_req    = (state_q == ST_ACK) && !Cin;
    state_d    = state_q;
    data_out_d = data_out_q;
    cin_acq_d  = cin_acq_q;
    case (state_q)
      ST_IDLE: begin
        if (Cin) begin
          if (!flush && !fifo_empty) begin
            data_out_d = fifo_head;
            cin_acq_d  = 1'b1;
            state_d    = ST_ACK;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (!Cin) begin
          state_d = ST_IDLE;
        end else if (!flush && (!fifo_empty || push_req)) begin
          // An empty FIFO here means the symbol arriving this edge is the head.
          data_out_d = fifo_empty ? key_symbol : fifo_head;
          cin_acq_d  = 1'b1;
          state_d    = ST_ACK;
        end
      end
      ST_ACK: begin
        if (!Cin) begin
          cin_acq_d = 1'b0;
          state_d   = ST_RELEASE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (flush)                         overflow_d = 1'b0;
    else if (push_req && !push_accept) overflow_d = 1'b1;
    else                               overflow_d = overflow_q;
  end

  // Handshake, edge-detect and overflow registers.
  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      key_prev_q <= 1'b0;
      data_out_q <= '0;
      cin_acq_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_prev_q <= key_prev_d;
      data_out_q <= data_out_d;
      cin_acq_q  <= cin_acq_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef CONSOLE_ECHO_EN
  logic                  echo_stb_q, echo_stb_d;
  logic [DATA_WIDTH-1:0] echo_symbol_q, echo_symbol_d;

  // Echo next values: strobe only on a symbol that entered the FIFO.
  always_comb begin
    echo_stb_d    = push_accept;
    echo_symbol_d = push_accept ? key_symbol : echo_symbol_q;
  end

  // Echo registers feeding the display's stdio writer.
  always_ff @(negedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      echo_stb_q    <= 1'b0;
      echo_symbol_q <= '0;
    end else begin
      echo_stb_q    <= echo_stb_d;
      echo_symbol_q <= echo_symbol_d;
    end
  end

  assign echo_stb    = echo_stb_q;
  assign echo_symbol = echo_symbol_q;
`else
  assign echo_stb    = 1'b0;
  assign echo_symbol = '0;
`endif

endmodule

// File: tb/tb_console_input.sv
// Bench for console_input: directed scenarios followed by random stimulus,
// every edge checked against a queue-based behavioural model.
module tb_console_input;
  localparam int DEPTH = 16;
`ifdef CONSOLE_ECHO_EN
  localparam bit ECHO = 1'b1;
`else
  localparam bit ECHO = 1'b0;
`endif

  logic       Clk = 1'b0;
  logic       Rst_n;
  logic [7:0] key_symbol;
  logic       key_pressed, flush, Cin;
  logic [7:0] data_out, echo_symbol;
  logic       CinAcq, empty, overflow, echo_stb;
  logic [4:0] fifo_count;

  int total = 0;
  int bad   = 0;

  // Behavioural model state.
  logic [7:0] mq[$];
  bit         m_prev, m_acq, m_rel, m_wait, m_ovf, m_estb;
  logic [7:0] m_dout, m_esym;

  console_input #(.DEPTH(DEPTH), .DATA_WIDTH(8)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .key_symbol(key_symbol), .key_pressed(key_pressed),
    .flush(flush), .Cin(Cin), .data_out(data_out), .CinAcq(CinAcq),
    .fifo_count(fifo_count), .empty(empty), .overflow(overflow),
    .echo_stb(echo_stb), .echo_symbol(echo_symbol)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_prev = 0; m_acq = 0; m_rel = 0; m_wait = 0; m_ovf = 0; m_estb = 0;
    m_dout = 8'h00; m_esym = 8'h00;
  endtask

  // One active edge of the console protocol, from the rules directly.
  task automatic model_edge();
    int         old_size;
    logic [7:0] old_front;
    bit         push_req, pop;
    old_size  = mq.size();
    old_front = (old_size > 0) ? mq[0] : 8'h00;
    push_req  = key_pressed && !m_prev && (key_symbol != 8'h00);
    m_prev    = key_pressed;
    pop       = m_acq && !Cin && (old_size > 0) && !flush;
    m_estb    = 0;
    if (flush) begin
      mq.delete();
      m_ovf = 0;
    end else begin
      if (pop) void'(mq.pop_front());
      if (push_req) begin
        if (mq.size() < DEPTH) begin
          mq.push_back(key_symbol);
          m_estb = 1; m_esym = key_symbol;
        end else begin
          m_ovf = 1;
        end
      end
    end
    if (m_acq) begin
      if (!Cin) begin m_acq = 0; m_rel = 1; end
    end else if (m_rel) begin
      m_rel = 0;
    end else if (!m_wait) begin
      if (Cin) begin
        if (!flush && old_size > 0) begin m_acq = 1; m_dout = old_front; end
        else m_wait = 1;
      end
    end else begin
      if (!Cin) m_wait = 0;
      else if (!flush && (old_size > 0 || push_req)) begin
        m_acq = 1; m_wait = 0;
        m_dout = (old_size > 0) ? old_front : key_symbol;
      end
    end
  endtask

  task automatic check_all();
    chk("data_out", 32'(data_out), 32'(m_dout));
    chk("CinAcq", 32'(CinAcq), 32'(m_acq));
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("empty", 32'(empty), 32'(mq.size() == 0));
    chk("overflow", 32'(overflow), 32'(m_ovf));
    chk("echo_stb", 32'(echo_stb), 32'(ECHO ? m_estb : 1'b0));
    chk("echo_symbol", 32'(echo_symbol), 32'(ECHO ? m_esym : 8'h00));
  endtask

  // Advance one active edge, update model, then sample outputs.
  task automatic step();
    @(negedge Clk);
    model_edge();
    #1;
    check_all();
    $display("edge t=%0t kp=%0b ks=%02h fl=%0b cin=%0b -> acq=%0b dout=%02h cnt=%0d ovf=%0b echo=%0b/%02h",
             $time, key_pressed, key_symbol, flush, Cin, CinAcq, data_out, fifo_count,
             overflow, echo_stb, echo_symbol);
  endtask

  task automatic press(input logic [7:0] sym);
    key_pressed = 1; key_symbol = sym; step();
    key_pressed = 0; step();
  endtask

  initial begin
    Rst_n = 0; key_symbol = 0; key_pressed = 0; flush = 0; Cin = 0;
    model_reset();
    #12;
    check_all();
    Rst_n = 1;
    step();

    // 1: single key delivered over the handshake
    press(8'h41);
    Cin = 1; step();
    chk("t1_acq", 32'(CinAcq), 32'd1);
    chk("t1_data", 32'(data_out), 32'h41);
    Cin = 0; step();
    chk("t1_acq_low", 32'(CinAcq), 32'd0);
    chk("t1_count", 32'(fifo_count), 32'd0);
    step();

    // 2: held key pushes once; zero symbol ignored
    key_pressed = 1; key_symbol = 8'h42;
    repeat (50) step();
    chk("t2_held", 32'(fifo_count), 32'd1);
    key_pressed = 0; step();
    press(8'h00);
    chk("t2_zero", 32'(fifo_count), 32'd1);
    Cin = 1; step(); Cin = 0; step(); step();

    // 3: request waits on empty FIFO, symbol bypassed on push edge
    Cin = 1;
    repeat (20) step();
    chk("t3_wait", 32'(CinAcq), 32'd0);
    key_pressed = 1; key_symbol = 8'h33; step();
    chk("t3_acq", 32'(CinAcq), 32'd1);
    chk("t3_data", 32'(data_out), 32'h33);
    key_pressed = 0; Cin = 0; step(); step();

    // 4: overflow on 17th symbol, ordered drain, flush clears overflow
    for (int i = 0; i < 17; i++) press(8'h50 + 8'(i));
    chk("t4_full", 32'(fifo_count), 32'd16);
    chk("t4_ovf", 32'(overflow), 32'd1);
    for (int i = 0; i < 16; i++) begin
      Cin = 1; step();
      chk("t4_drain", 32'(data_out), 32'h50 + 32'(i));
      Cin = 0; step(); step();
    end
    chk("t4_empty", 32'(empty), 32'd1);
    flush = 1; step(); flush = 0;
    chk("t4_ovf_clr", 32'(overflow), 32'd0);

    // 5: push on a full FIFO coincident with pop; flush during ACK
    for (int i = 0; i < 16; i++) press(8'h60 + 8'(i));
    Cin = 1; step();
    Cin = 0; key_pressed = 1; key_symbol = 8'h7E; step();
    chk("t5_count", 32'(fifo_count), 32'd16);
    chk("t5_noovf", 32'(overflow), 32'd0);
    key_pressed = 0; step();
    for (int i = 0; i < 16; i++) begin
      Cin = 1; step(); Cin = 0; step(); step();
    end
    chk("t5_last", 32'(data_out), 32'h7E);
    press(8'h11); press(8'h22);
    Cin = 1; step();
    flush = 1; step(); flush = 0;
    chk("t5_hold", 32'(CinAcq), 32'd1);
    chk("t5_flushed", 32'(fifo_count), 32'd0);
    step();
    chk("t5_hold2", 32'(CinAcq), 32'd1);
    Cin = 0; step();
    chk("t5_release", 32'(CinAcq), 32'd0);
    chk("t5_count0", 32'(fifo_count), 32'd0);
    step();

    // 6: echo strobe on accepted push only
    key_pressed = 1; key_symbol = 8'h0D; step();
    chk("t6_stb", 32'(echo_stb), 32'(ECHO));
    chk("t6_sym", 32'(echo_symbol), ECHO ? 32'h0D : 32'h00);
    key_pressed = 0; step();
    chk("t6_stb_off", 32'(echo_stb), 32'd0);
    for (int i = 0; i < 15; i++) press(8'h80 + 8'(i));
    key_pressed = 1; key_symbol = 8'hEE; step();
    chk("t6_ovf_nostb", 32'(echo_stb), 32'd0);
    chk("t6_ovf", 32'(overflow), 32'd1);
    key_pressed = 0; flush = 1; step(); flush = 0; step();

    // Reset mid-handshake drops CinAcq immediately
    press(8'h5A);
    Cin = 1; step();
    #2 Rst_n = 0; Cin = 0;
    #1;
    model_reset();
    chk("rst_acq", 32'(CinAcq), 32'd0);
    chk("rst_count", 32'(fifo_count), 32'd0);
    #1 Rst_n = 1;
    step();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 3) == 0) key_pressed = ~key_pressed;
      if ($urandom_range(0, 4) == 0)
        key_symbol = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
      flush = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 2) == 0) Cin = ~Cin;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/console_input.md
Name: console_input

Overview:
- Console-input end of the CPU console I/O path: the counterpart of the display-side output path (Cout/CioAcq).
- Captures key symbols from the keyboard decoder into a small FIFO.
- Delivers one symbol per CPU input request over a four-phase Cin/CinAcq handshake.
- Optionally echoes accepted symbols to the display's stdio writer.

Parameters:
- DEPTH, 16, FIFO entries; power of two, minimum 2.
- DATA_WIDTH, 8, symbol width in bits.

Ports:
- Clk  input  1  system clock; all state updates on negedge Clk.
- Rst_n  input  1  asynchronous active-low reset.
- key_symbol  input  DATA_WIDTH  decoded key code; valid while key_pressed=1.
- key_pressed  input  1  level, high while a symbol key is held.
- flush  input  1  synchronous FIFO clear (driven from the hard-reset key).
- Cin  input  1  CPU input request, four-phase.
- data_out  output  DATA_WIDTH  symbol presented to the CPU.
- CinAcq  output  1  data_out valid; held until Cin falls.
- fifo_count  output  $clog2(DEPTH)+1  current occupancy.
- empty  output  1  fifo_count==0.
- overflow  output  1  sticky: a keypress was dropped.
- echo_stb  output  1  one-cycle strobe per accepted symbol (ECHO only).
- echo_symbol  output  DATA_WIDTH  accepted symbol (ECHO only).

Behaviour:
- Reset (async, Rst_n=0):
  - FIFO pointers 0, fifo_count=0, empty=1, overflow=0.
  - data_out=0, CinAcq=0, echo_stb=0, echo_symbol=0.
  - key edge register=0, handshake FSM=IDLE.
  - Reset mid-handshake aborts it; CinAcq drops immediately.
- Capture:
  - Push request = rising edge of key_pressed (registered previous level) AND key_symbol!=0.
  - Holding a key yields exactly one push; a zero symbol is ignored.
- Push rules:
  - If not full: write at tail; tail++, count++.
  - If full and no pop on the same edge: drop the symbol, set overflow.
  - If full with a pop on the same edge: accept; count stays DEPTH.
- Pointer arithmetic: pointers are $clog2(DEPTH) bits and wrap modulo DEPTH. fifo_count is one bit wider and saturates at exactly DEPTH.
- FSM states (IDLE, WAIT, ACK, RELEASE):
  - IDLE: Cin=1 and !empty → data_out<=head, CinAcq<=1, go ACK. Cin=1 and empty → WAIT.
  - WAIT: when !empty → data_out<=head, CinAcq<=1, go ACK. A push and the load on the same edge is allowed; the pushed symbol is bypassed to data_out. Cin dropping while in WAIT → IDLE with no ack.
  - ACK: hold data_out and CinAcq while Cin=1. On Cin=0: CinAcq<=0, pop head (head++, count--), go RELEASE.
  - RELEASE: one cycle; go IDLE. Guarantees CinAcq is low for at least one cycle before the next acknowledge.
- Latency: Cin sampled high with a non-empty FIFO → CinAcq high after the same negedge (one edge).
- Simultaneous push and pop: both happen; count unchanged.
- flush=1:
  - Pointers and count go to 0; overflow is cleared.
  - A push on the same edge is discarded.
  - In ACK: CinAcq and data_out hold until Cin falls; the pop is suppressed because the FIFO is already empty.
  - In WAIT: stay in WAIT.
- data_out keeps its last value outside ACK.

Optional Feature:
- Macro: CONSOLE_ECHO_EN.
- Defined:
  - Every accepted push drives echo_stb=1 for one cycle, with echo_symbol=the pushed symbol.
  - A dropped push (overflow) gives no echo.
  - Intended to feed the display's stdio write port, the same path as Cout.
- Undefined:
  - echo_stb tied to 0, echo_symbol tied to 0; no echo logic is synthesized.

Decomposition:
- Shared package:
  - enum typedef for the handshake states (IDLE, WAIT, ACK, RELEASE).
  - Constant CONSOLE_NULL_SYMBOL=8'h00.
  - Default CONSOLE_FIFO_DEPTH=16.
- One sub-module, sync_fifo: storage array, pointers, count, full/empty, simultaneous push/pop rule.
- console_input keeps edge detection, the FSM, overflow and echo.

Test Plan:
1. Reset, press/release key_symbol=8'h41 once; raise Cin → CinAcq=1 with data_out=8'h41 one edge later; drop Cin → CinAcq=0, fifo_count back to 0.
2. Hold key_pressed high for 50 cycles with 8'h42 → fifo_count=1, not 50. Pulse with key_symbol=0 → no push.
3. Raise Cin with the FIFO empty; wait 20 cycles; press 8'h33 → CinAcq=1 with data_out=8'h33 on the push edge.
4. Push 17 distinct symbols with DEPTH=16 → fifo_count=16, overflow=1. Drain → the first 16 symbols in order, the 17th absent. Assert flush → overflow=0.
5. With FIFO full, push on the same edge as a Cin-fall pop → count stays 16, new symbol present last; flush during ACK → CinAcq held until Cin falls, then count=0.
6. With CONSOLE_ECHO_EN defined, push 8'h0D → echo_stb high exactly one cycle with echo_symbol=8'h0D. Overflowed push → no strobe. With the macro undefined, echo_stb is always 0.
